// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, issues single outstanding reads to
// instruction memory, buffers up to two fetched instructions for decode,
// predecodes unconditional jumps and honours execute-stage redirects.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC    = 8'd0,
  parameter logic [2:0] JUMP_OPCODE = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_valid,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_target
);

  typedef enum logic [1:0] {StIssue, StWait, StStall} state_e;

  state_e            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [7:0]        addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [1:0]        count_q, count_d;
  // Each entry is {instr, pc}; entry 0 is the head.
  logic [1:0][15:0]  fifo_q, fifo_d;

  logic              push;
  logic              pop;
  logic [1:0]        count_after;
  logic              wr_idx;
  logic              is_jump;

  assign push        = (state_q == StWait) && mem_valid && !drop_q && !redirect_valid;
  assign pop         = (count_q != 2'd0) && instr_ready;
  assign count_after = count_q + {1'b0, push} - {1'b0, pop};
  // Write slot for a push: behind the surviving head, or slot 0 when empty.
  assign wr_idx      = (count_q == 2'd1) && !pop;
  assign is_jump     = (mem_data[7:5] == JUMP_OPCODE);

  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = fifo_q[0][15:8];
  assign instr_pc    = fifo_q[0][7:0];
  // During a request the address comes straight from the PC, afterwards it is
  // held so a redirect cannot disturb the outstanding read.
  assign mem_addr    = (state_q == StIssue) ? pc_q : addr_q;

  // Next-state, PC and request control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    mem_req = 1'b0;

    unique case (state_q)
      StIssue: begin
        // A redirect in the issue cycle suppresses the stale request.
        if (!redirect_valid && !reset) begin
          mem_req = 1'b1;
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StIssue;
          end else begin
            pc_d    = is_jump ? {3'b000, mem_data[4:0]} : pc_q + 8'd1;
            state_d = (count_after < 2'd2) ? StIssue : StStall;
          end
        end
      end
      StStall: begin
        if (count_after < 2'd2) state_d = StIssue;
      end
      default: state_d = StIssue;
    endcase

    // Redirect wins over predecode and push; an unanswered read must be dropped.
    if (redirect_valid) begin
      pc_d = redirect_target;
      if (state_q == StWait && !mem_valid) begin
        drop_d  = 1'b1;
        state_d = StWait;
      end else begin
        drop_d  = 1'b0;
        state_d = StIssue;
      end
    end
  end

  // FIFO next-state: flush on redirect, otherwise shift on pop and append on push
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wr_idx] = {mem_data, pc_q};
      count_d = count_after;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= 1'b0;
      count_q <= 2'd0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory.
module tb_instruction_fetch;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
  } deliv_t;

  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic [7:0] pc;
    logic [7:0] instr;
    logic       req;
    logic [7:0] addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_valid = 1'b0;
  logic [7:0] mem_addr, mem_data = 8'h00;
  logic       instr_valid, instr_ready = 1'b1;
  logic [7:0] instr_out, instr_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_target = 8'h00;

  // Second instance for PC wrap: always-zero memory, latency 1
  logic       mem_req2, mem_valid2 = 1'b0;
  logic [7:0] mem_addr2;
  logic       instr_valid2;
  logic [7:0] instr_out2, instr_pc2;
  logic [7:0] mem_data2 = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [256];
  int         lat = 1;
  int         lat_cnt = 0;
  logic       keep_stray = 1'b0;
  logic [7:0] hold_addr = 8'h00;
  logic       saw6 = 1'b0;
  int         req_pulses = 0;
  logic [7:0] req2_log [$];
  logic [15:0] got [$];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  instruction_fetch #(.RESET_PC(8'hFF), .JUMP_OPCODE(3'b010)) dut2 (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_valid(mem_valid2), .mem_data(mem_data2), .instr_valid(instr_valid2),
    .instr_ready(1'b1), .instr_out(instr_out2), .instr_pc(instr_pc2),
    .redirect_valid(1'b0), .redirect_target(8'h00)
  );

  // Memory model: sample requests mid-cycle, answer `lat` cycles later
  always begin : mem_model
    logic       req_seen, req2_seen;
    logic [7:0] a;
    @(negedge clk);
    req_seen  = mem_req;
    a         = mem_addr;
    req2_seen = mem_req2;
    if (mem_req2) req2_log.push_back(mem_addr2);
    if (reset && !keep_stray) lat_cnt = 0;
    @(posedge clk);
    #1;
    mem_valid  = 1'b0;
    mem_valid2 = req2_seen;
    if (req_seen) begin
      hold_addr = a;
      lat_cnt   = lat;
      req_pulses++;
      if (a == 8'd6) saw6 = 1'b1;
    end
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = prog[hold_addr];
      end
    end
  end

  // Record every instruction handed to decode
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) got.push_back({instr_pc, instr_out});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hold reset for three edges and release one step after an edge (cycle 1 begins)
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    deliv_t t1 [7];
    vec_t   t2 [14];
    int     start, idx2, n0, waited;
    logic   found, stray;

    for (int i = 0; i < 256; i++) prog[i] = 8'h60 | (i[7:0] & 8'h1F);
    prog[0] = 8'h85; prog[1] = 8'h99; prog[2] = 8'hAF; prog[3] = 8'h30;
    prog[4] = 8'h0D; prog[5] = 8'h47; prog[6] = 8'hB0; prog[7] = 8'h77;

    t1[0] = '{8'd0, 8'h85}; t1[1] = '{8'd1, 8'h99}; t1[2] = '{8'd2, 8'hAF};
    t1[3] = '{8'd3, 8'h30}; t1[4] = '{8'd4, 8'h0D}; t1[5] = '{8'd5, 8'h47};
    t1[6] = '{8'd7, 8'h77};

    t2[0] = '{1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 8'd0};
    t2[1] = '{1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'd0};
    t2[2] = '{1'b0, 1'b1, 8'd0, 8'h85, 1'b1, 8'd1};
    for (int i = 3; i < 10; i++) t2[i] = '{1'b0, 1'b1, 8'd0, 8'h85, 1'b0, 8'd0};
    t2[10] = '{1'b1, 1'b1, 8'd0, 8'h85, 1'b0, 8'd0};
    t2[11] = '{1'b1, 1'b1, 8'd1, 8'h99, 1'b1, 8'd2};
    t2[12] = '{1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 8'd0};
    t2[13] = '{1'b1, 1'b1, 8'd2, 8'hAF, 1'b1, 8'd3};

    // Reset values
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr_out", instr_out, 8'h00);
    check("rst_instr_pc", instr_pc, 8'h00);
    check("rst_mem_addr_ff", mem_addr2, 8'hFF);

    // Program run with jump at pc 5, plus PC wrap on the second instance
    lat = 1; instr_ready = 1'b1;
    do_reset();
    start = got.size();
    idx2  = req2_log.size();
    repeat (18) @(posedge clk);
    check("t1_count_ok", (got.size() - start) >= 7, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (start + i < got.size()) check($sformatf("t1_deliv%0d", i), got[start + i], t1[i]);
    end
    check("t1_b0_not_fetched", saw6, 1'b0);
    check("wrap_have_two", (req2_log.size() - idx2) >= 2, 1'b1);
    if (req2_log.size() - idx2 >= 2) begin
      check("wrap_addr0", req2_log[idx2], 8'hFF);
      check("wrap_addr1", req2_log[idx2 + 1], 8'h00);
    end

    // Decode stall: cycle-by-cycle vectors
    lat = 1; instr_ready = 1'b0;
    do_reset();
    start = got.size();
    n0 = req_pulses;
    for (int i = 0; i < 14; i++) begin
      instr_ready = t2[i].rdy;
      @(negedge clk);
      check($sformatf("t2_c%0d_valid", i + 1), instr_valid, t2[i].vld);
      if (t2[i].vld) check($sformatf("t2_c%0d_head", i + 1), {instr_pc, instr_out},
                           {t2[i].pc, t2[i].instr});
      check($sformatf("t2_c%0d_req", i + 1), mem_req, t2[i].req);
      if (t2[i].req) check($sformatf("t2_c%0d_addr", i + 1), mem_addr, t2[i].addr);
      if (i == 9) check("t2_req_pulses_full", req_pulses - n0, 2);
      @(posedge clk);
      #1;
    end
    check("t2_deliv_count", got.size() - start, 3);
    for (int i = 0; i < 3; i++) begin
      if (start + i < got.size()) check($sformatf("t2_deliv%0d_pc", i), got[start + i][15:8], i);
    end

    // Redirect while waiting on pc 3 with latency 4
    lat = 4; instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'd3) found = 1'b1;
    end
    check("t3_req3_seen", found, 1'b1);
    if (found) begin
      #1 instr_ready = 1'b0;
      @(posedge clk);
      #1 redirect_valid = 1'b1; redirect_target = 8'h40;
      @(negedge clk);
      check("t3_pre_head", {instr_valid, instr_pc}, {1'b1, 8'd2});
      @(posedge clk);
      #1 redirect_valid = 1'b0; instr_ready = 1'b1;
      n0 = got.size();
      @(negedge clk);
      check("t3_flush_valid", instr_valid, 1'b0);
      found = 1'b0; waited = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (mem_req) found = 1'b1;
        else begin
          waited++;
          @(negedge clk);
        end
      end
      check("t3_new_req_seen", found, 1'b1);
      check("t3_new_req_addr", mem_addr, 8'h40);
      check("t3_waited_for_drop", waited >= 2, 1'b1);
      for (int i = 0; i < 20 && got.size() == n0; i++) @(negedge clk);
      check("t3_deliv_seen", got.size() > n0, 1'b1);
      if (got.size() > n0) check("t3_first_after", got[n0], {8'h40, prog[8'h40]});
    end

    // Redirect in the same cycle as a jump response
    lat = 1; instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'd5) found = 1'b1;
    end
    check("t4_req5_seen", found, 1'b1);
    if (found) begin
      @(posedge clk);
      #1 redirect_valid = 1'b1; redirect_target = 8'h60;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      n0 = got.size();
      @(negedge clk);
      check("t4_req", mem_req, 1'b1);
      check("t4_addr", mem_addr, 8'h60);
      for (int i = 0; i < 20 && got.size() == n0; i++) @(negedge clk);
      check("t4_deliv_seen", got.size() > n0, 1'b1);
      if (got.size() > n0) check("t4_first_after", got[n0], {8'h60, prog[8'h60]});
    end

    // Reset asserted mid-WAIT; the stray response lands while reset is held
    lat = 4; instr_ready = 1'b1;
    do_reset();
    keep_stray = 1'b1;
    @(negedge clk);
    check("t5_first_req", {mem_req, mem_addr}, {1'b1, 8'h00});
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_async_req", mem_req, 1'b0);
    check("t5_async_valid", instr_valid, 1'b0);
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_valid) stray = 1'b1;
      check($sformatf("t5_rst_valid%0d", i), instr_valid, 1'b0);
    end
    check("t5_stray_seen", stray, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0; keep_stray = 1'b0;
    @(negedge clk);
    check("t5_post_req", {mem_req, mem_addr}, {1'b1, 8'h00});
    check("t5_post_valid0", instr_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_post_valid%0d", i + 1), instr_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
